// File: rtl/de2_led_pkg.sv
// Shared defaults and width helpers for the DE2 green-LED output conditioning stage.
package de2_led_pkg;

  localparam int unsigned DE2_NUM_LEDG     = 9;
  localparam int unsigned LED_TICK_DIV_1MS = 50000;
  localparam int unsigned LED_STRETCH_DEF  = 50;
  localparam int unsigned LED_PWM_BITS     = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // A zero stretch still needs a 1-bit counter so the channel logic elaborates.
  function automatic int unsigned cnt_width(input int unsigned stretch);
    int unsigned w;
    w = clog2(stretch + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: reload-on-level stretch counter that decays on prescaler ticks.
module led_stretch_chan
  import de2_led_pkg::*;
#(
  parameter int unsigned STRETCH_TICKS = LED_STRETCH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic tick,
  output logic active
);

  localparam int unsigned     CW   = cnt_width(STRETCH_TICKS);
  localparam logic [CW-1:0]   LOAD = CW'(STRETCH_TICKS);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over a coincident tick so a retrigger never loses a tick's worth of on-time.
  always_comb begin
    cnt_d = cnt_q;
    if (level) begin
      cnt_d = LOAD;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = level | (cnt_q != '0);

endmodule

// File: rtl/de2_led_stretch_pwm.sv
// LEDG output stage: registers the PIO word, pulse-stretches each bit and applies global PWM dimming.
module de2_led_stretch_pwm
  import de2_led_pkg::*;
#(
  parameter int unsigned N_LEDS        = DE2_NUM_LEDG,
  parameter int unsigned TICK_DIV      = LED_TICK_DIV_1MS,
  parameter int unsigned STRETCH_TICKS = LED_STRETCH_DEF,
  parameter int unsigned PWM_BITS      = LED_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_LEDS-1:0]   led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   ledg,
  output logic                tick
);

  localparam int unsigned   PW       = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [N_LEDS-1:0]   led_q;
  logic [PW-1:0]       pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_LEDS-1:0]   ledg_q, ledg_d;
  logic [N_LEDS-1:0]   active;
  logic                pwm_on;

  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    tick_d = (pre_q == PRE_LAST);
    pwm_d  = pwm_q + 1'b1;
    pwm_on = (brightness == '1) || (pwm_q < brightness);
    ledg_d = active & {N_LEDS{pwm_on}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      ledg_q <= '0;
    end else begin
      led_q  <= led_in;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
      ledg_q <= ledg_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    led_stretch_chan #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .level (led_q[i]),
      .tick  (tick_q),
      .active(active[i])
    );
  end

  assign ledg = ledg_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_de2_led_stretch_pwm.sv
// Self-checking bench: stretching DUT (TICK_DIV=4, STRETCH_TICKS=3) beside a no-stretch DUT on shared inputs.
module tb_de2_led_stretch_pwm;

  localparam int N  = 9;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] led_in = '0;
  logic [3:0]   brightness = 4'hF;
  logic [N-1:0] ledg, ledg0;
  logic         tick, tick0;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int           edge_n;
    logic [N-1:0] exp_s;
    logic [N-1:0] exp_n;
  } sb_t;

  sb_t          sbq[$];
  int           end_k[N];
  logic [N-1:0] last_obs;

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  de2_led_stretch_pwm #(
    .N_LEDS(N), .TICK_DIV(TD), .STRETCH_TICKS(ST), .PWM_BITS(4)
  ) u_dut (
    .clk(clk), .reset(reset), .led_in(led_in), .brightness(brightness),
    .ledg(ledg), .tick(tick)
  );

  de2_led_stretch_pwm #(
    .N_LEDS(N), .TICK_DIV(TD), .STRETCH_TICKS(0), .PWM_BITS(4)
  ) u_dut0 (
    .clk(clk), .reset(reset), .led_in(led_in), .brightness(brightness),
    .ledg(ledg0), .tick(tick0)
  );

  // Last edge at which an output stays high after a load seen at edge l (ticks land on edges k%TD==0).
  function automatic int last_on(input int l);
    int t;
    t = ((l + TD - 1) / TD) * TD;
    return t + (ST - 1) * TD + 1;
  endfunction

  task automatic apply_reset();
    led_in = '0;
    brightness = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    foreach (end_k[i]) end_k[i] = -1;
  endtask

  task automatic run_word(input logic [N-1:0] w);
    sb_t e;
    int  l;
    @(negedge clk);
    last_obs = ledg;
    if (sbq.size() > 0 && sbq[0].edge_n == cyc) begin
      e = sbq.pop_front();
      checks++;
      if (ledg !== e.exp_s) begin
        errors++;
        $display("FAIL stretch_ledg edge %0d: got %h expected %h", cyc, ledg, e.exp_s);
      end
      checks++;
      if (ledg0 !== e.exp_n) begin
        errors++;
        $display("FAIL nostretch_ledg edge %0d: got %h expected %h", cyc, ledg0, e.exp_n);
      end
    end
    led_in = w;
    l = cyc + 2;
    for (int i = 0; i < N; i++) if (w[i]) end_k[i] = last_on(l);
    e.edge_n = l;
    e.exp_n  = w;
    for (int i = 0; i < N; i++) e.exp_s[i] = (l <= end_k[i]);
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    int n;
    checks++;
    if (ledg !== '0 || tick !== 1'b0 || ledg0 !== '0) begin
      errors++;
      $display("FAIL reset_state: got ledg=%h tick=%b ledg0=%h expected 0 0 0", ledg, tick, ledg0);
    end
    @(negedge clk);
    reset = 1'b0;
    led_in = '1;
    brightness = 4'hF;
    repeat (6) @(negedge clk);
    checks++;
    if (ledg !== '1) begin
      errors++;
      $display("FAIL pre_reset_ledg: got %h expected 1ff", ledg);
    end
    n = 0;
    while (n < 10 && tick !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout: got %b expected 1", tick);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ledg !== '0 || tick !== 1'b0 || ledg0 !== '0) begin
      errors++;
      $display("FAIL async_reset: got ledg=%h tick=%b ledg0=%h expected 0 0 0", ledg, tick, ledg0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (tick === 1'b1) break;
    end
    checks++;
    if (n != TD) begin
      errors++;
      $display("FAIL first_tick_delay: got %0d cycles expected %0d", n, TD);
    end
  endtask

  task automatic test_pwm();
    logic [3:0]   brs[4];
    logic [N-1:0] want;
    int           hi;
    int           hi_want;
    brs[0] = 4'd4; brs[1] = 4'd0; brs[2] = 4'd15; brs[3] = 4'd9;
    led_in = '1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      brightness = brs[b];
      hi = 0;
      for (int n = 0; n < 32; n++) begin
        @(negedge clk);
        want = (brs[b] == 4'hF || ((cyc - 1) % 16) < int'(brs[b])) ? '1 : '0;
        checks++;
        if (ledg !== want) begin
          errors++;
          $display("FAIL pwm_ledg br=%0d edge %0d: got %h expected %h", brs[b], cyc, ledg, want);
        end
        checks++;
        if (ledg0 !== want) begin
          errors++;
          $display("FAIL pwm_ledg0 br=%0d edge %0d: got %h expected %h", brs[b], cyc, ledg0, want);
        end
        if (ledg[0]) hi++;
      end
      hi_want = (brs[b] == 4'hF) ? 32 : 2 * int'(brs[b]);
      checks++;
      if (hi != hi_want) begin
        errors++;
        $display("FAIL pwm_duty br=%0d: got %0d expected %0d", brs[b], hi, hi_want);
      end
    end
  endtask

  task automatic test_single_pulse();
    int hi;
    run_word(9'h001);
    hi = 0;
    repeat (20) begin
      run_word('0);
      if (last_obs[0]) hi++;
    end
    checks++;
    if (hi < (ST - 1) * TD + 2 || hi > ST * TD + 1) begin
      errors++;
      $display("FAIL pulse_on_time: got %0d cycles expected %0d..%0d", hi, (ST - 1) * TD + 2, ST * TD + 1);
    end
  endtask

  task automatic test_retrigger();
    int t1;
    int target;
    int low3;
    run_word(9'h028);
    t1 = (((cyc + 2) + TD - 1) / TD) * TD;
    // Counter is 1 with tick high before edge t1+9; the reload must land on that edge.
    target = t1 + (ST - 1) * TD - 1;
    while (cyc + 1 < target) run_word('0);
    run_word(9'h008);
    low3 = 0;
    repeat (10) begin
      run_word('0);
      if (!last_obs[3]) low3++;
    end
    checks++;
    if (low3 != 0) begin
      errors++;
      $display("FAIL retrigger_continuous: got %0d low cycles expected 0", low3);
    end
    repeat (20) run_word('0);
  endtask

  task automatic test_walk();
    for (int i = 0; i < N; i++) run_word(N'(1) << i);
    repeat (2) run_word('0);
    checks++;
    if (last_obs !== '1) begin
      errors++;
      $display("FAIL walk_all_on: got %h expected 1ff", last_obs);
    end
    repeat (4 * TD + 4) run_word('0);
    checks++;
    if (last_obs !== '0 || ledg0 !== '0) begin
      errors++;
      $display("FAIL walk_all_off: got %h/%h expected 000/000", last_obs, ledg0);
    end
  endtask

  task automatic test_no_stretch();
    repeat (40) run_word(N'($urandom_range(0, 511)));
    repeat (20) run_word('0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_pwm();
    apply_reset();
    test_single_pulse();
    test_retrigger();
    test_walk();
    test_no_stretch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
